// File: rtl/vga_capture.sv
// vga_capture: sink end of the VGA pixel interface.
// Samples the VGA signals and recovers the pixel coordinates from them.
// It produces a frame-buffer write stream {h, v, rgb} and monitors the frame geometry.
// Optional feature macro: VGA_CAPTURE_CRC_EN adds a CRC-16-CCITT over each completed frame.
// When the macro is not defined, frame_crc is tied to zero.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        vga_valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        wr_en,
  output logic [9:0]  wr_h_addr,
  output logic [8:0]  wr_v_addr,
  output logic [23:0] wr_data,
  output logic        frame_done,
  output logic        locked,
  output logic        geom_err,
  output logic [15:0] frame_crc
);

  localparam logic [9:0] H_MAX = 10'(H_ACTIVE);
  localparam logic [8:0] V_MAX = 9'(V_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VSYNC  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t      state_r, state_nx_s;
  logic        hs_act1_r, vs_act1_r, val1_r, vs_act2_r, val2_r;
  logic [23:0] rgb1_r;
  logic        sof_s, eol_s, pix_s;
  logic [9:0]  h_cnt_r, h_nx_s;
  logic [8:0]  v_cnt_r, v_nx_s;
  logic        ferr_r, ferr_nx_s;
  logic        wr_nx_s, done_nx_s, lock_nx_s, gerr_nx_s, restart_s;

  // Input stage S1 (sync converted to "asserted") plus one-cycle history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_act1_r <= 1'b0;
      vs_act1_r <= 1'b0;
      val1_r    <= 1'b0;
      rgb1_r    <= 24'h000000;
      vs_act2_r <= 1'b0;
      val2_r    <= 1'b0;
    end else begin
      hs_act1_r <= (vga_hsync == SYNC_POL);
      vs_act1_r <= (vga_vsync == SYNC_POL);
      val1_r    <= vga_valid;
      rgb1_r    <= {vga_r, vga_g, vga_b};
      vs_act2_r <= vs_act1_r;
      val2_r    <= val1_r;
    end
  end

  // A pixel seen while hsync is asserted is treated as blank; a valid VGA stream never does that
  assign sof_s = vs_act1_r & ~vs_act2_r;
  assign eol_s = val2_r & ~val1_r;
  assign pix_s = val1_r & ~hs_act1_r;

  // Next-state, counter and flag logic; an EOL in the SOF cycle is counted before the frame closes
  always_comb begin
    state_nx_s = state_r;
    h_nx_s     = h_cnt_r;
    v_nx_s     = v_cnt_r;
    ferr_nx_s  = ferr_r;
    gerr_nx_s  = geom_err;
    lock_nx_s  = locked;
    wr_nx_s    = 1'b0;
    done_nx_s  = 1'b0;
    restart_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sof_s) begin
          state_nx_s = ST_VSYNC;
          restart_s  = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_VSYNC: begin
        if (!vs_act1_r) begin
          state_nx_s = ST_ACTIVE;
        end else begin
          state_nx_s = ST_VSYNC;
        end
      end
      ST_ACTIVE: begin
        if (pix_s) begin
          if ((h_cnt_r < H_MAX) && (v_cnt_r < V_MAX)) begin
            wr_nx_s = 1'b1;
            h_nx_s  = h_cnt_r + 10'd1;
          end else begin
            ferr_nx_s = 1'b1;
            gerr_nx_s = 1'b1;
          end
        end else if (eol_s) begin
          if (h_cnt_r != H_MAX) begin
            ferr_nx_s = 1'b1;
            gerr_nx_s = 1'b1;
          end else begin
            ferr_nx_s = ferr_r;
          end
          if (v_cnt_r != V_MAX) begin
            v_nx_s = v_cnt_r + 9'd1;
          end else begin
            v_nx_s = V_MAX;
          end
          h_nx_s = 10'd0;
        end else begin
          h_nx_s = h_cnt_r;
        end
        if (sof_s) begin
          if ((v_nx_s == V_MAX) && !ferr_nx_s) begin
            done_nx_s = 1'b1;
            lock_nx_s = 1'b1;
          end else begin
            lock_nx_s = 1'b0;
            gerr_nx_s = 1'b1;
          end
          restart_s  = 1'b1;
          state_nx_s = ST_VSYNC;
        end else begin
          state_nx_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    if (restart_s) begin
      h_nx_s    = 10'd0;
      v_nx_s    = 9'd0;
      ferr_nx_s = 1'b0;
    end else begin
      ferr_nx_s = ferr_nx_s;
    end
  end

  // State, counters and registered write/status outputs (stage S2)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      h_cnt_r    <= 10'd0;
      v_cnt_r    <= 9'd0;
      ferr_r     <= 1'b0;
      wr_en      <= 1'b0;
      wr_h_addr  <= 10'd0;
      wr_v_addr  <= 9'd0;
      wr_data    <= 24'h000000;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      geom_err   <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      h_cnt_r    <= h_nx_s;
      v_cnt_r    <= v_nx_s;
      ferr_r     <= ferr_nx_s;
      wr_en      <= wr_nx_s;
      frame_done <= done_nx_s;
      locked     <= lock_nx_s;
      geom_err   <= gerr_nx_s;
      if (wr_nx_s) begin
        wr_h_addr <= h_cnt_r;
        wr_v_addr <= v_cnt_r;
        wr_data   <= rgb1_r;
      end
    end
  end

`ifdef VGA_CAPTURE_CRC_EN
  // CRC-16-CCITT (poly 0x1021) over one 24-bit pixel, MSB first
  function automatic logic [15:0] crc16_24(input logic [15:0] crc, input logic [23:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [15:0] crc_r, crc_upd_s;

  assign crc_upd_s = wr_nx_s ? crc16_24(crc_r, rgb1_r) : crc_r;

  // Running CRC restarts at each SOF; the frame result is latched only for a good frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_r     <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else begin
      crc_r <= restart_s ? 16'hFFFF : crc_upd_s;
      if (done_nx_s) begin
        frame_crc <= crc_upd_s;
      end
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule
